scratchpad_dma_ctrl: RTL
========================

// Module: scratchpad_dma_ctrl
// PURPOSE
//  Sequencer between the tensor core's scratchpad and the memory arbiter. Accepts load/store
//  commands, each moving one ROWSxDATA_W matrix tile. Load: drives sLoad, collects the per-row
//  sLoad_hit beats into a local tile slot. Store: drives sStore once per row from a slot.
//  The tensor core reads/writes slots through a simple row port.
// PARAMETERS
//  ROWS        4   rows per tile; must equal the arbiter load loop count (4)
//  DATA_W      64  bits per row (two 32b memory words)
//  ADDR_W      32  byte address width
//  NSLOT       4   tile slots held locally
//  ROW_STRIDE  8   byte stride between consecutive rows in memory
// PORTS
//  CLK         in   1       clock
//  nRST        in   1       reset, asynchronous, active-low
//  cmd_valid   in   1       command offered
//  cmd_ready   out  1       command accepted when valid&ready
//  cmd_op      in   1       0=load (mem->slot), 1=store (slot->mem)
//  cmd_addr    in   ADDR_W  tile base byte address, bits[2:0] must be 0
//  cmd_slot    in   log2(NSLOT)  target/source slot
//  done        out  1       1-cycle pulse at command completion
//  err         out  1       1-cycle pulse: misaligned cmd, row mismatch, or write to busy slot
//  slot_valid  out  NSLOT   bit set when slot holds a completed load
//  rd_slot     in   log2(NSLOT)  tensor-core read slot
//  rd_row      in   log2(ROWS)   tensor-core read row
//  rd_data     out  DATA_W  combinational read of slot[rd_slot].row[rd_row]
//  wr_en       in   1       tensor-core row write
//  wr_slot/wr_row/wr_data  in  log2(NSLOT)/log2(ROWS)/DATA_W
//  sLoad       out  1       load request to arbiter
//  load_addr   out  ADDR_W  tile base for load (held for whole load)
//  sLoad_hit   in   1       row beat valid
//  sLoad_row   in   3       row index of beat
//  load_data   in   DATA_W  row data of beat
//  sStore      out  1       store request to arbiter (one row per request)
//  store_addr  out  ADDR_W  base + row*ROW_STRIDE
//  store_data  out  DATA_W  slot[cur_slot].row[row]
//  sStore_hit  in   1       current row written
// BEHAVIOUR
//  Reset: state IDLE, row_cnt=0, sLoad=sStore=0, done=err=0, slot_valid=0, cmd_ready=1,
//   load_addr=store_addr=0; slot storage is not reset.
//  FSM IDLE/LOAD/STORE. cmd_ready=1 only in IDLE.
//  IDLE: on valid&ready latch op/addr/slot. Misaligned addr (addr[2:0]!=0) -> err pulse next
//   cycle, stay IDLE. Load -> LOAD, clear slot_valid[slot]. Store -> STORE.
//  LOAD: sLoad = (state==LOAD) && !(sLoad_hit && row_cnt==ROWS-1), combinational, so the
//   arbiter sees it low in the cycle it returns to idle and never restarts the sequence.
//   Each sLoad_hit: write load_data into slot[cur_slot].row[row_cnt], row_cnt++.
//   sLoad_row!=row_cnt -> err pulse; data is still written at row_cnt.
//   Last hit -> IDLE next cycle, done pulse, slot_valid[slot]=1, row_cnt=0.
//  STORE: sStore registered, high from the first STORE cycle. Outputs store_addr and
//   store_data for row_cnt. Each sStore_hit: row_cnt++. On the last hit sStore drops next
//   cycle, done pulse, IDLE. Between rows sStore stays high with the new row's addr/data.
//  Arithmetic: store_addr = base + row_cnt*ROW_STRIDE, modulo 2^ADDR_W (wraps, no error).
//  Tensor port: wr_en to the slot of an active LOAD or STORE is ignored and pulses err.
//   Otherwise the write occurs at the clock edge. A write to a slot_valid slot keeps it valid.
//   rd_data is combinational. Same-cycle write+read of one row returns old data.
//  Hit with no matching request active (sLoad_hit outside LOAD, sStore_hit outside STORE):
//   ignored.
//  Reset mid-operation: sLoad/sStore drop immediately and the command is lost.
//   slot_valid for that slot is 0.
// TESTING
//  load addr 0x100 slot 2; model returns rows R0..R3 -> slot2 rows match, done pulse,
//   slot_valid=0100, sLoad low the cycle of the 4th hit.
//  store slot 1 addr 0x200 -> store_addr 0x200,0x208,0x210,0x218 with rows 0..3, 4 hits, done.
//  cmd_addr 0x104 -> err pulse, no sLoad/sStore, cmd_ready stays 1.
//  wr_en slot 2 during its load -> err, slot 2 data equals loaded rows.
//  sLoad_row=2 on the first hit -> err, data stored at row 0, load completes.
//  nRST low after 2 load hits -> sLoad=0 immediately, slot_valid=0, next command accepted.

Source files
------------

// File: rtl/scratchpad_dma_ctrl.sv
// Tile sequencer between the tensor-core scratchpad and the memory arbiter.
// Moves ROWS x DATA_W tiles between local slots and memory via sLoad/sStore.
module scratchpad_dma_ctrl #(
   parameter int ROWS       = 4,
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 32,
   parameter int NSLOT      = 4,
   parameter int ROW_STRIDE = 8,
   localparam int SW = $clog2(NSLOT),
   localparam int RW = $clog2(ROWS)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [SW-1:0]     cmd_slot,
   output logic              done,
   output logic              err,
   output logic [NSLOT-1:0]  slot_valid,
   input  logic [SW-1:0]     rd_slot,
   input  logic [RW-1:0]     rd_row,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [SW-1:0]     wr_slot,
   input  logic [RW-1:0]     wr_row,
   input  logic [DATA_W-1:0] wr_data,
   output logic              sLoad,
   output logic [ADDR_W-1:0] load_addr,
   input  logic              sLoad_hit,
   input  logic [2:0]        sLoad_row,
   input  logic [DATA_W-1:0] load_data,
   output logic              sStore,
   output logic [ADDR_W-1:0] store_addr,
   output logic [DATA_W-1:0] store_data,
   input  logic              sStore_hit
);

   typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

   state_t            state;
   logic [RW-1:0]     row_cnt;
   logic [SW-1:0]     cur_slot;
   logic              last_row;
   logic              wr_blocked;
   logic [DATA_W-1:0] mem [NSLOT][ROWS];

   assign last_row   = (row_cnt == RW'(ROWS - 1));
   assign wr_blocked = wr_en && (state != IDLE) && (wr_slot == cur_slot);
   assign cmd_ready  = (state == IDLE);
   // Drops in the cycle of the final beat so the arbiter never restarts its loop.
   assign sLoad      = (state == LOAD) && !(sLoad_hit && last_row);
   assign rd_data    = mem[rd_slot][rd_row];
   assign store_data = mem[cur_slot][row_cnt];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         row_cnt    <= '0;
         cur_slot   <= '0;
         sStore     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         slot_valid <= '0;
         load_addr  <= '0;
         store_addr <= '0;
      end else begin
         done <= 1'b0;
         err  <= wr_blocked;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cur_slot <= cmd_slot;
                  row_cnt  <= '0;
                  if (cmd_addr[2:0] != 3'd0) begin
                     err <= 1'b1;
                  end else if (!cmd_op) begin
                     state                <= LOAD;
                     load_addr            <= cmd_addr;
                     slot_valid[cmd_slot] <= 1'b0;
                  end else begin
                     state      <= STORE;
                     store_addr <= cmd_addr;
                     sStore     <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (sLoad_hit) begin
                  if (sLoad_row != 3'(row_cnt)) err <= 1'b1;
                  if (last_row) begin
                     state                <= IDLE;
                     done                 <= 1'b1;
                     slot_valid[cur_slot] <= 1'b1;
                     row_cnt              <= '0;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end
            end
            STORE: begin
               if (sStore_hit) begin
                  if (last_row) begin
                     state   <= IDLE;
                     sStore  <= 1'b0;
                     done    <= 1'b1;
                     row_cnt <= '0;
                  end else begin
                     row_cnt    <= row_cnt + 1'b1;
                     // Running sum equals base + row_cnt*ROW_STRIDE modulo 2^ADDR_W.
                     store_addr <= store_addr + ADDR_W'(ROW_STRIDE);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (state == LOAD && sLoad_hit) mem[cur_slot][row_cnt] <= load_data;
      if (wr_en && !wr_blocked) mem[wr_slot][wr_row] <= wr_data;
   end

endmodule
